// File: rtl/adc_display_pkg.sv
// rtl/adc_display_pkg.sv - shared defaults and FSM encoding for the ADC voltage display path
// Contents:
//   ADC_WIDTH_DEF, AVG_LOG2_DEF, VREF_DV_DEF : default sample width, averaging window, full scale
//   DV_MAX, DD_ITERS                         : display clamp (9.9 V) and double-dabble iteration count
//   adc_state_e                              : conversion FSM states
package adc_display_pkg;

    localparam int ADC_WIDTH_DEF = 12;
    localparam int AVG_LOG2_DEF  = 4;
    localparam int VREF_DV_DEF   = 33;

    // Two BCD digits can show at most 9.9 V.
    localparam int DV_MAX        = 99;
    // One double-dabble iteration per bit of the 7-bit voltage.
    localparam int DD_ITERS      = 7;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_SCALE = 2'd1,
        ST_CONV  = 2'd2,
        ST_DONE  = 2'd3
    } adc_state_e;

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble, 7-bit binary to two BCD digits
// Ports:
//   sys_clk, rst_n : clock, asynchronous active-low reset (drops any conversion in flight)
//   start          : load bin; iterations run on the following DD_ITERS edges
//   bin            : 7-bit binary value (0..99)
//   done           : high during the cycle whose closing edge performs the last iteration
//   bcd            : {tens, ones} BCD digits; final once the last iteration has run
module bin2bcd_seq
    import adc_display_pkg::*;
(
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] bin,
    output logic       done,
    output logic [7:0] bcd
);

    // {tens[3:0], ones[3:0], bin[6:0]}
    logic [14:0] sh_q, sh_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        run_q, run_d;
    logic [14:0] adj;

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        run_d = run_q;

        // Add-3 correction on any digit >= 5 so the following shift carries correctly.
        adj = sh_q;
        if (adj[10:7] >= 4'd5) begin
            adj[10:7] = adj[10:7] + 4'd3;
        end
        if (adj[14:11] >= 4'd5) begin
            adj[14:11] = adj[14:11] + 4'd3;
        end

        if (start) begin
            sh_d  = {8'd0, bin};
            cnt_d = 3'd0;
            run_d = 1'b1;
        end else if (run_q) begin
            sh_d  = {adj[13:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (done) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign done = run_q && (cnt_q == 3'(DD_ITERS - 1));
    assign bcd  = sh_q[14:7];

endmodule

// File: rtl/adc_voltage_bcd.sv
// rtl/adc_voltage_bcd.sv - averages ADC samples and presents the voltage as packed BCD
// Ports:
//   sys_clk, rst_n       : clock, asynchronous active-low reset
//   adc_data, adc_valid  : raw unsigned sample and its one-cycle qualifier
//   oled_display_digital : [7:4] = volts, [3:0] = tenths of a volt, held between updates
//   update               : one-cycle pulse when oled_display_digital is reloaded
//   busy                 : high while scaling or converting to BCD
module adc_voltage_bcd
    import adc_display_pkg::*;
#(
    parameter int ADC_WIDTH = ADC_WIDTH_DEF,
    parameter int AVG_LOG2  = AVG_LOG2_DEF,
    parameter int VREF_DV   = VREF_DV_DEF
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic [ADC_WIDTH-1:0] adc_data,
    input  logic                 adc_valid,
    output logic [7:0]           oled_display_digital,
    output logic                 update,
    output logic                 busy
);

    localparam int ACC_W  = ADC_WIDTH + AVG_LOG2;
    // Eight extra bits keep avg * VREF_DV exact for any VREF_DV up to 255.
    localparam int PROD_W = ADC_WIDTH + 8;

    adc_state_e            state_q, state_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [AVG_LOG2-1:0]   cnt_q, cnt_d;
    logic [ADC_WIDTH-1:0]  avg_q, avg_d;
    logic [7:0]            out_q, out_d;
    logic                  update_q, update_d;

    logic [ACC_W-1:0]      sum;
    logic                  win_done;
    logic [PROD_W-1:0]     prod;
    logic [7:0]            dv_full;
    logic [6:0]            dv;
    logic                  bcd_start;
    logic                  bcd_done;
    logic [7:0]            bcd;

    // Scaling works from the registered average, so no sample input reaches an output.
    always_comb begin
        prod    = PROD_W'(avg_q) * PROD_W'(VREF_DV);
        dv_full = 8'(prod >> ADC_WIDTH);
        dv      = (dv_full > 8'(DV_MAX)) ? 7'(DV_MAX) : dv_full[6:0];
    end

    assign bcd_start = (state_q == ST_SCALE);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        avg_d    = avg_q;
        out_d    = out_q;
        update_d = 1'b0;
        win_done = 1'b0;

        // Accumulation runs in every state; the closing sample is folded into the
        // average directly and the next window starts from zero on the same edge.
        sum = acc_q + ACC_W'(adc_data);
        if (adc_valid) begin
            if (&cnt_q) begin
                acc_d    = '0;
                cnt_d    = '0;
                win_done = 1'b1;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_ACCUM: begin
                if (win_done) begin
                    avg_d   = sum[ACC_W-1:AVG_LOG2];
                    state_d = ST_SCALE;
                end
            end
            ST_SCALE: begin
                state_d = ST_CONV;
            end
            ST_CONV: begin
                if (bcd_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_d    = bcd;
                update_d = 1'b1;
                state_d  = ST_ACCUM;
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ACCUM;
            acc_q    <= '0;
            cnt_q    <= '0;
            avg_q    <= '0;
            out_q    <= 8'h00;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            avg_q    <= avg_d;
            out_q    <= out_d;
            update_q <= update_d;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .start   (bcd_start),
        .bin     (dv),
        .done    (bcd_done),
        .bcd     (bcd)
    );

    assign oled_display_digital = out_q;
    assign update               = update_q;
    assign busy                 = (state_q == ST_SCALE) || (state_q == ST_CONV);

endmodule

// File: tb/tb_adc_voltage_bcd.sv
// tb/tb_adc_voltage_bcd.sv - directed self-checking bench for adc_voltage_bcd
module tb_adc_voltage_bcd;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic [11:0] adc_data;
    logic        adc_valid;
    logic [7:0]  oled;
    logic        update;
    logic        busy;
    logic [7:0]  oled_hv;
    logic        update_hv;
    logic        busy_hv;

    int total = 0;
    int bad   = 0;

    always #5 sys_clk = ~sys_clk;

    adc_voltage_bcd dut (
        .sys_clk              (sys_clk),
        .rst_n                (rst_n),
        .adc_data             (adc_data),
        .adc_valid            (adc_valid),
        .oled_display_digital (oled),
        .update               (update),
        .busy                 (busy)
    );

    adc_voltage_bcd #(.VREF_DV(120)) dut_hv (
        .sys_clk              (sys_clk),
        .rst_n                (rst_n),
        .adc_data             (adc_data),
        .adc_valid            (adc_valid),
        .oled_display_digital (oled_hv),
        .update               (update_hv),
        .busy                 (busy_hv)
    );

    // Background monitor on the default instance.
    int         mon_upd     = 0;
    int         mon_busy    = 0;
    int         mon_dbl     = 0;
    int         mon_unstable = 0;
    logic [7:0] mon_last    = 8'h00;
    logic       prev_upd    = 1'b0;
    logic [7:0] prev_oled   = 8'h00;

    always @(negedge sys_clk) begin
        if (rst_n) begin
            if (update) begin
                mon_upd  = mon_upd + 1;
                mon_last = oled;
                if (prev_upd) mon_dbl = mon_dbl + 1;
            end else if (oled != prev_oled) begin
                mon_unstable = mon_unstable + 1;
            end
            if (busy) mon_busy = mon_busy + 1;
        end
        prev_upd  = update;
        prev_oled = oled;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Drives n valid samples, each preceded by 0..gap_max idle cycles; leaves the last one on the bus.
    task automatic feed(input logic [11:0] s, input int n, input int gap_max);
        for (int i = 0; i < n; i++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int j = 0; j < g; j++) begin
                @(negedge sys_clk);
                adc_valid = 1'b0;
            end
            @(negedge sys_clk);
            adc_data  = s;
            adc_valid = 1'b1;
        end
    endtask

    // Called right after feed: lat = edges from the closing sample to the update pulse.
    task automatic wait_update(output int lat, output int bcyc);
        @(negedge sys_clk);
        adc_valid = 1'b0;
        lat  = 0;
        bcyc = busy ? 1 : 0;
        while (!update && lat < 40) begin
            @(negedge sys_clk);
            lat++;
            if (busy) bcyc++;
        end
    endtask

    typedef struct {
        logic [11:0] sample;
        logic [7:0]  exp_bcd;
        logic [7:0]  exp_hv;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int lat;
        int bcyc;
        int upd0;
        int busy0;

        vecs[0] = '{12'd2048, 8'h16, 8'h60};
        vecs[1] = '{12'd4095, 8'h32, 8'h99};
        vecs[2] = '{12'd0,    8'h00, 8'h00};
        vecs[3] = '{12'd1241, 8'h09, 8'h36};

        rst_n     = 1'b0;
        adc_data  = 12'd0;
        adc_valid = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("reset_oled", oled, 8'h00);
        chk("reset_update", update, 0);
        chk("reset_busy", busy, 0);
        chk("reset_oled_hv", oled_hv, 8'h00);
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            feed(vecs[v].sample, 16, 0);
            wait_update(lat, bcyc);
            chk($sformatf("lat_%0d", v), lat, 9);
            chk($sformatf("busy_cycles_%0d", v), bcyc, 8);
            chk($sformatf("bcd_%0d", v), oled, vecs[v].exp_bcd);
            chk($sformatf("bcd_hv_%0d", v), oled_hv, vecs[v].exp_hv);
            chk($sformatf("upd_hv_%0d", v), update_hv, 1);
            @(negedge sys_clk);
            chk($sformatf("upd_single_%0d", v), update, 0);
            chk($sformatf("hold_%0d", v), oled, vecs[v].exp_bcd);
            repeat (3) @(negedge sys_clk);
        end

        // Gapped window followed by a contiguous one that accumulates during the first conversion.
        upd0  = mon_upd;
        busy0 = mon_busy;
        feed(12'd2048, 16, 5);
        feed(12'd2048, 16, 0);
        @(negedge sys_clk);
        adc_valid = 1'b0;
        repeat (30) @(negedge sys_clk);
        chk("gap_updates", mon_upd - upd0, 2);
        chk("gap_busy", mon_busy - busy0, 16);
        chk("gap_value", mon_last, 8'h16);
        chk("no_double_pulse", mon_dbl, 0);
        chk("oled_stable", mon_unstable, 0);

        // Reset in the middle of a conversion; samples presented during reset must be ignored.
        feed(12'd4095, 16, 0);
        @(negedge sys_clk);
        adc_valid = 1'b0;
        repeat (4) @(negedge sys_clk);
        chk("pre_rst_busy", busy, 1);
        rst_n     = 1'b0;
        adc_data  = 12'd4095;
        adc_valid = 1'b1;
        #1;
        chk("rst_oled", oled, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_update", update, 0);
        chk("rst_oled_hv", oled_hv, 8'h00);
        repeat (3) @(negedge sys_clk);
        adc_valid = 1'b0;
        rst_n     = 1'b1;
        feed(12'd4095, 16, 0);
        wait_update(lat, bcyc);
        chk("post_rst_lat", lat, 9);
        chk("post_rst_bcd", oled, 8'h32);
        chk("post_rst_bcd_hv", oled_hv, 8'h99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
